// File: rtl/rng_sample_buffer_if.sv
// Handshake bundle between the RNG producer, the sample buffer and its reader.
// slave = buffer side, master = producer/reader side.
`ifndef RNG_BY
`define RNG_BY 16
`endif

interface rng_sample_buffer_if #(
    parameter int BY = `RNG_BY,
    parameter int LW = 4
);
    logic [BY-1:0] sample;
    logic          sample_valid;
    logic          rng_restart;
    logic          read;
    logic [BY-1:0] out;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          underflow;
    logic [15:0]   sample_count;

    modport slave (
        input  sample, sample_valid, read,
        output rng_restart, out, out_valid, level,
        output empty, full, underflow, sample_count
    );

    modport master (
        output sample, sample_valid, read,
        input  rng_restart, out, out_valid, level,
        input  empty, full, underflow, sample_count
    );
endinterface

// File: rtl/rng_sample_buffer.sv
// Captures RNG samples on valid rising edges into a FIFO and restarts the producer.
// Optional capture counter enabled by defining RNG_BUF_STATS_EN.
`ifndef RNG_BY
`define RNG_BY 16
`endif

module rng_sample_buffer #(
    parameter int BY             = `RNG_BY,
    parameter int DEPTH          = 8,
    parameter int RESTART_CYCLES = 2,
    parameter int LW             = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic rst,
    rng_sample_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RESTART_CYCLES - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        WAIT,
        RESTART,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          valid_q;

    logic [BY-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic          empty_q;
    logic          full_q;
    logic          underflow_q;
    logic [BY-1:0] out_q;
    logic          out_valid_q;

    logic          rise;
    logic          pop;
    logic          wr;

    // Capture only on a fresh rising edge in WAIT; a full FIFO accepts
    // the write only when a pop frees a slot in the same cycle.
    always_comb begin
        rise      = bus.sample_valid && !valid_q;
        pop       = bus.read && !empty_q;
        wr        = (state == WAIT) && rise && (!full_q || pop);
        level_nxt = level_q + LW'(wr) - LW'(pop);
    end

    // Next-state logic of the capture FSM, decided on post-update level.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT: begin
                if (wr) begin
                    state_nxt = (level_nxt == LVL_FULL) ? HOLD : RESTART;
                end
            end
            RESTART: begin
                if (cnt == '0) begin
                    state_nxt = WAIT;
                end
            end
            HOLD: begin
                if (!full_q) begin
                    state_nxt = RESTART;
                end
            end
            default: state_nxt = WAIT;
        endcase
    end

    // State register, restart down-counter and valid edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_q <= bus.sample_valid;
            if (state_nxt == RESTART && state != RESTART) begin
                cnt <= CNT_LOAD;
            end else if (state == RESTART && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= bus.sample;
        end
    end

    // Pointers, occupancy flags and the registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            underflow_q <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                out_q  <= mem[rd_ptr];
            end
            out_valid_q <= pop;
            level_q     <= level_nxt;
            empty_q     <= (level_nxt == '0);
            full_q      <= (level_nxt == LVL_FULL);
            if (bus.read && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

`ifdef RNG_BUF_STATS_EN
    logic [15:0] count_q;

    // Saturating count of FIFO writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (wr && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.sample_count = count_q;
`else
    assign bus.sample_count = '0;
`endif

    assign bus.rng_restart = (state == RESTART);
    assign bus.out         = out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.level       = level_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_rng_sample_buffer.sv
// Scoreboard bench for rng_sample_buffer: acts as RNG producer and reader.
// Expected samples are queued when presented and popped on out_valid.
module tb_rng_sample_buffer;
    logic clk;
    logic rst;

    rng_sample_buffer_if #(.BY(16), .LW(4)) bus ();

    rng_sample_buffer #(
        .BY(16),
        .DEPTH(8),
        .RESTART_CYCLES(2),
        .LW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every popped sample must match the oldest presented one.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", 32'(bus.out), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(bus.out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.sample = '0;
        bus.sample_valid = 1'b0;
        bus.read = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_restart_end();
        int n = 0;
        while (bus.rng_restart && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("restart_timeout", 0, 1);
    endtask

    // Present one sample; drop valid once restarted, or return held if full.
    task automatic produce(input logic [15:0] v);
        int n = 0;
        bus.sample = v;
        bus.sample_valid = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        while (!bus.rng_restart && !bus.full && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("capture_timeout", 0, 1);
        if (bus.rng_restart) begin
            bus.sample_valid = 1'b0;
            wait_restart_end();
        end
    endtask

    task automatic do_read();
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        chk("rd_valid", 32'(bus.out_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (!bus.empty && n < 20) begin
            do_read();
            n++;
        end
        chk("drained", 32'(bus.empty), 1);
    endtask

    initial begin
        int cnt;

        // Reset and idle
        do_reset();
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_restart", 32'(bus.rng_restart), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_underflow", 32'(bus.underflow), 0);
        chk("rst_count", 32'(bus.sample_count), 0);

        // Read while empty
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        chk("uf_out_valid", 32'(bus.out_valid), 0);
        chk("uf_set", 32'(bus.underflow), 1);
        repeat (4) @(negedge clk);
        chk("uf_sticky", 32'(bus.underflow), 1);
        do_reset();
        chk("uf_cleared", 32'(bus.underflow), 0);

        // Single sample held high for 5 cycles
        bus.sample = 16'h1234;
        bus.sample_valid = 1'b1;
        exp_q.push_back(16'h1234);
        @(negedge clk);
        chk("single_level", 32'(bus.level), 1);
        chk("single_rs_first", 32'(bus.rng_restart), 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.sample_valid = 1'b0;
            if (bus.rng_restart) cnt++;
            @(negedge clk);
        end
        chk("single_rs_len", 32'(cnt), 2);
        chk("single_one_write", 32'(bus.level), 1);
`ifdef RNG_BUF_STATS_EN
        chk("single_count", 32'(bus.sample_count), 1);
`else
        chk("single_count", 32'(bus.sample_count), 0);
`endif
        do_read();
        @(negedge clk);
        chk("single_ov_pulse", 32'(bus.out_valid), 0);
        chk("single_empty", 32'(bus.empty), 1);

        // Fill to full, producer stalls in HOLD
        for (int i = 1; i <= 8; i++) produce(16'(i));
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_level", 32'(bus.level), 8);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rng_restart) cnt++;
            @(negedge clk);
        end
        chk("hold_no_restart", 32'(cnt), 0);
        chk("hold_level", 32'(bus.level), 8);
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        chk("hold_lvl7", 32'(bus.level), 7);
        chk("hold_rs_wait", 32'(bus.rng_restart), 0);
        @(negedge clk);
        chk("hold_rs_start", 32'(bus.rng_restart), 1);
        bus.sample_valid = 1'b0;
        wait_restart_end();
        chk("hold_lvl_after", 32'(bus.level), 7);
        drain();

        // Order and pointer wrap, reads interleaved
        for (int i = 1; i <= 20; i++) begin
            produce(16'(i));
            if (i % 3 != 0) do_read();
        end
        chk("wrap_level", 32'(bus.level), 6);
        drain();

        // Simultaneous write and pop at level 3
        produce(16'd31);
        produce(16'd32);
        produce(16'd33);
        chk("sim_pre", 32'(bus.level), 3);
        bus.sample = 16'd34;
        bus.sample_valid = 1'b1;
        exp_q.push_back(16'd34);
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        chk("sim_level", 32'(bus.level), 3);
        chk("sim_ov", 32'(bus.out_valid), 1);
        chk("sim_rs", 32'(bus.rng_restart), 1);
        bus.sample_valid = 1'b0;
        wait_restart_end();
        drain();

        // Asynchronous reset during RESTART
        bus.sample = 16'h00AA;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        chk("ar_in_restart", 32'(bus.rng_restart), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_rs_drop", 32'(bus.rng_restart), 0);
        chk("ar_level", 32'(bus.level), 0);
        chk("ar_empty", 32'(bus.empty), 1);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_count0", 32'(bus.sample_count), 0);
        for (int i = 0; i < 3; i++) produce(16'h0A00 + 16'(i));
`ifdef RNG_BUF_STATS_EN
        chk("ar_count3", 32'(bus.sample_count), 3);
`else
        chk("ar_count3", 32'(bus.sample_count), 0);
`endif
        drain();
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rng_sample_buffer.md
# rng_sample_buffer

Consumer side of the non-uniform RNG sample interface. Detects each new sample presented by the `rng` producer (`rng`/`valid`), stores it in a small FIFO, then pulses the producer's restart input so the producer generates the next sample. Serves buffered samples to downstream logic through a single-cycle read-request port. Sits between `rng` and any block drawing random variates, for example the Newton-iteration datapath.

## Interface
- `BY`, default `` `RNG_BY ``: sample width in bits.
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `RESTART_CYCLES`, default 2: width of the restart pulse in cycles; must be at least 1.
- `LW`, default `$clog2(DEPTH)+1`: width of the `level` port.

Ports (clock and reset first):
- `clk` in, 1: single clock; everything is on its rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `sample` in, BY: producer data, connected to `rng.rng`.
- `sample_valid` in, 1: producer valid, connected to `rng.valid`. Level signal; stays high until the producer is restarted.
- `rng_restart` out, 1: OR'd into the producer's `rst`; requests the next sample.
- `read` in, 1: downstream read request, one sample per high cycle.
- `out` out, BY: registered read data.
- `out_valid` out, 1: `out` holds a newly popped sample this cycle.
- `level` out, LW: current FIFO occupancy, 0 to DEPTH.
- `empty` out, 1: high when `level` == 0.
- `full` out, 1: high when `level` == DEPTH.
- `underflow` out, 1: sticky; set by any `read` while empty.
- `sample_count` out, 16: number of captured samples (see Configuration).

## Operation
- Capture FSM states: WAIT, RESTART, HOLD. Reset state is WAIT.
- An edge register `valid_q` holds the previous cycle's `sample_valid`; it resets to 0.
- WAIT: when `sample_valid && !valid_q`, `sample` is written to the FIFO.
  - Go to RESTART if the FIFO is not full after the write.
  - Otherwise go to HOLD.
- RESTART: `rng_restart` = 1 for exactly RESTART_CYCLES cycles (down-counter), then go to WAIT.
- HOLD: `rng_restart` = 0 and the producer stalls with its sample presented. Go to RESTART in the cycle after `level` drops below DEPTH.
- The capture rule only accepts a rising edge of `sample_valid`, so a held-high `sample_valid` is never captured twice.
- A rising edge seen in RESTART or HOLD is ignored. It cannot occur with a correct producer.
- Read path:
  - `read && !empty`: pop the head into `out`; `out_valid` = 1 on the next cycle.
  - `read && empty`: `out` is unchanged, `out_valid` = 0, `underflow` is set.
  - Without `read`: `out_valid` = 0 and `out` holds its last value.
- Simultaneous write and pop in one cycle: both happen and `level` is unchanged.
  - Write while full cannot occur, because WAIT entered full and would have gone to HOLD.
  - Exception: at `level` == DEPTH with a same-cycle pop, the write is accepted. The next state is computed on the post-update level.
- Pointers are log2(DEPTH) bits and wrap naturally. `level` is a separate counter.
- Reset values: `out` = 0, `out_valid` = 0, `rng_restart` = 0, `level` = 0, `empty` = 1, `full` = 0, `underflow` = 0, `sample_count` = 0, FIFO pointers = 0.
- Reset mid-operation: all state clears asynchronously and FIFO contents are discarded. `rng_restart` drops immediately; the producer is already reset by the shared `rst`.

## Timing
- Capture: `sample_valid` first seen high at edge n. The FIFO is written at edge n, so `level` and `empty` update after edge n.
- `rng_restart` is high for cycles n+1 … n+RESTART_CYCLES. WAIT is re-entered after edge n+RESTART_CYCLES.
- Read latency: `read` high at edge m gives `out`/`out_valid` valid after edge m. The sample is readable on the cycle following the request.
- The earliest a captured sample can be read is at the edge after its capture, so capture-to-out is 2 edges.
- `full` and `empty` are registered and consistent with `level` every cycle.
- Sustained throughput is limited by the producer. The buffer adds RESTART_CYCLES+1 cycles per sample.

## Configuration
- Macro `RNG_BUF_STATS_EN`.
- Defined: `sample_count` increments on every FIFO write and saturates at 16'hFFFF.
- Undefined: no counter logic; `sample_count` is tied to 0.
- FIFO, FSM and read behaviour are identical in both builds.

## Test plan
- Reset then idle: all outputs are at their reset values. `read` pulse → `out_valid` = 0, `underflow` = 1 and stays 1 until `rst`.
- Single sample: producer raises `sample_valid` with `sample` = 16'h1234 and holds it high for 5 cycles.
  - Exactly one write; `level` = 1.
  - `rng_restart` high for exactly 2 cycles, starting the cycle after capture.
  - `read` → `out` = 16'h1234, `out_valid` for 1 cycle.
- Fill: 8 samples 1…8, no reads.
  - After the 8th, `full` = 1, FSM in HOLD, `rng_restart` stays 0 with `sample_valid` held high.
  - One `read` → `out` = 1, then a restart pulse begins the cycle after `level` = 7.
- Order and wrap: 20 samples interleaved with reads → `out` sequence matches input order 1…20, crossing the pointer wrap twice.
- Simultaneous write and read at `level` = 3 → `level` stays 3 and the correct head is output.
- `rst` asserted asynchronously during RESTART → `rng_restart` drops before the next edge and `level` = 0. With `RNG_BUF_STATS_EN` defined, `sample_count` = 0; after 3 further captures it reads 3.
